mean_shift_window_accum: RTL and testbench
==========================================

Name: mean_shift_window_accum

Overview:
- Streaming accumulator directly downstream of the 8s x 8s -> 16s product stage in the MeanShiftFiltering datapath.
- Sums the signed 16-bit weighted-pixel products of one mean-shift window into a wide saturating accumulator, and counts the accepted samples.
- Hands one {sum, count, saturation flag} result per window to the divide/centroid stage over a valid/ready handshake.

Parameters:
- DIN_WIDTH, 16, width of the signed product input.
- ACC_WIDTH, 24, width of the signed accumulator and out_sum; must be >= DIN_WIDTH.
- CNT_WIDTH, 7, width of the sample counter and out_count.
- MAX_LEN, 64, maximum samples per window; must be <= 2^CNT_WIDTH - 1.

Ports:
- ap_clk  in  1  clock; all state updates on the rising edge.
- ap_rst  in  1  synchronous, active-high reset.
- in_data  in  DIN_WIDTH  signed product (two's complement).
- in_last  in  1  marks the final sample of a window; qualified by in_valid.
- in_valid  in  1  in_data/in_last valid.
- in_ready  out  1  block can accept a sample this cycle.
- out_sum  out  ACC_WIDTH  signed window sum (saturated).
- out_count  out  CNT_WIDTH  number of samples accumulated in the window.
- out_sat  out  1  set if saturation occurred at any point in the window.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.

Behaviour:
- States: S_ACC (accumulating) and S_OUT (result held).
- Reset (ap_rst=1 at an edge): state=S_ACC; acc=0; cnt=0; sat=0; out_sum=0; out_count=0; out_sat=0; out_valid=0.
- in_ready is 0 while ap_rst=1, regardless of state.
- in_ready = (state==S_ACC) and not ap_rst. It depends on state only, never on in_valid.
- Accept condition: in_valid && in_ready.
- On accept:
  - acc <= sat(acc + sign_extend(in_data)), computed at ACC_WIDTH+1 bits.
  - If the result is above 2^(ACC_WIDTH-1)-1, clamp to that value and set sat.
  - If the result is below -2^(ACC_WIDTH-1), clamp to that value and set sat.
  - cnt <= cnt+1.
- Window termination: an accepted sample with in_last=1, or the accepted sample that makes cnt reach MAX_LEN, whichever comes first.
- On termination:
  - The terminating sample is included in the sum.
  - Next edge: out_sum, out_count and out_sat are loaded with the final values; out_valid=1; state=S_OUT.
  - Latency from the terminating accept to out_valid is 1 cycle.
- S_OUT:
  - in_ready=0; in_valid is ignored and no sample is consumed.
  - out_sum, out_count, out_sat and out_valid are held stable until out_valid && out_ready.
- On out_valid && out_ready:
  - Next edge: out_valid=0; acc=0; cnt=0; sat=0; state=S_ACC.
  - in_ready becomes 1 in that same following cycle.
  - out_sum/out_count/out_sat keep their last values; they are don't-care while out_valid=0.
- out_ready may already be high when out_valid rises; the handshake then completes in the first S_OUT cycle. Minimum gap between windows is 1 bubble cycle.
- Once saturated, the accumulator keeps summing from the clamped value (it does not freeze). sat stays sticky until the window is handed off.
- If in_last arrives on the same sample where cnt reaches MAX_LEN, the window terminates once, with no double output.
- out_count is never 0 on a valid result. Empty windows are impossible because termination requires an accepted sample.
- Reset mid-window or mid-S_OUT discards the partial window or pending result. No output is produced for it.
- No combinational path from in_valid or out_ready to any output.

Test Plan:
- Reset then 4 samples {100, -50, 300, 7}, last on the 4th -> out_valid exactly 1 cycle after the 4th accept; out_sum=357, out_count=4, out_sat=0.
- 64 samples of 1, in_last never asserted -> result after the 64th: out_sum=64, out_count=64; in_ready=0 until handoff.
- 300 samples of +32767 with last on the 300th, MAX_LEN=512 / CNT_WIDTH=10 override -> out_sum=8388607 and out_sat=1; then a -1 window (1 sample) -> out_sum=-1, out_sat=0 (sticky flag cleared).
- Hold out_ready=0 for 10 cycles while in_valid=1 with new data -> outputs stable, no samples consumed. Release out_ready -> handshake, then the next window sums only the post-release samples.
- Single-sample window in_data=-32768, in_last=1, out_ready tied 1 -> out_sum=-32768, out_count=1; back-to-back windows accept one sample every 2 cycles.
- Assert ap_rst for 1 cycle after 3 accepted samples -> no output. The next window {5, 5} with last -> out_sum=10, out_count=2.

Source files
------------

// File: rtl/mean_shift_window_accum_if.sv
// rtl/mean_shift_window_accum_if.sv - product-in / window-result-out handshake bundle
interface mean_shift_window_accum_if #(
    parameter int DIN_WIDTH = 16,
    parameter int ACC_WIDTH = 24,
    parameter int CNT_WIDTH = 7
);
    logic signed [DIN_WIDTH-1:0] in_data;
    logic                        in_last;
    logic                        in_valid;
    logic                        in_ready;
    logic signed [ACC_WIDTH-1:0] out_sum;
    logic        [CNT_WIDTH-1:0] out_count;
    logic                        out_sat;
    logic                        out_valid;
    logic                        out_ready;

    // Producer of samples and consumer of results (product stage / divider side)
    modport master (
        output in_data, in_last, in_valid, out_ready,
        input  in_ready, out_sum, out_count, out_sat, out_valid
    );

    // The accumulator itself
    modport slave (
        input  in_data, in_last, in_valid, out_ready,
        output in_ready, out_sum, out_count, out_sat, out_valid
    );
endinterface

// File: rtl/mean_shift_window_accum.sv
// rtl/mean_shift_window_accum.sv - saturating per-window sum and sample count of signed products
module mean_shift_window_accum #(
    parameter int DIN_WIDTH = 16,
    parameter int ACC_WIDTH = 24,
    parameter int CNT_WIDTH = 7,
    parameter int MAX_LEN   = 64
) (
    input  logic                        ap_clk,
    input  logic                        ap_rst,
    mean_shift_window_accum_if.slave    bus
);

    typedef enum logic {
        S_ACC = 1'b0,
        S_OUT = 1'b1
    } state_t;

    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    localparam logic [CNT_WIDTH-1:0]        MAX_CNT = CNT_WIDTH'(MAX_LEN);

    state_t                      state_q, state_d;
    logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
    logic        [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                        sat_q, sat_d;
    logic signed [ACC_WIDTH-1:0] out_sum_q, out_sum_d;
    logic        [CNT_WIDTH-1:0] out_count_q, out_count_d;
    logic                        out_sat_q, out_sat_d;
    logic                        out_valid_q, out_valid_d;

    logic                        accept;
    logic        [ACC_WIDTH:0]   sum_wide;
    logic                        sum_ovf;
    logic signed [ACC_WIDTH-1:0] sum_clamped;
    logic        [CNT_WIDTH-1:0] cnt_inc;
    logic                        window_end;

    // Ready follows state alone so the upstream never sees a loop through in_valid
    assign bus.in_ready  = (state_q == S_ACC) && !ap_rst;
    assign bus.out_sum   = out_sum_q;
    assign bus.out_count = out_count_q;
    assign bus.out_sat   = out_sat_q;
    assign bus.out_valid = out_valid_q;

    // One-bit-wider add; the two top bits disagree exactly when the true sum leaves the range
    always_comb begin
        accept     = bus.in_valid && bus.in_ready;
        sum_wide   = {acc_q[ACC_WIDTH-1], acc_q}
                   + {{(ACC_WIDTH+1-DIN_WIDTH){bus.in_data[DIN_WIDTH-1]}}, bus.in_data};
        sum_ovf    = sum_wide[ACC_WIDTH] != sum_wide[ACC_WIDTH-1];
        if (!sum_ovf) begin
            sum_clamped = sum_wide[ACC_WIDTH-1:0];
        end else if (sum_wide[ACC_WIDTH]) begin
            sum_clamped = ACC_MIN;
        end else begin
            sum_clamped = ACC_MAX;
        end
        cnt_inc    = cnt_q + 1'b1;
        window_end = bus.in_last || (cnt_inc == MAX_CNT);
    end

    // Next-state: accumulate while S_ACC, publish on the terminating sample, clear on handoff
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        sat_d       = sat_q;
        out_sum_d   = out_sum_q;
        out_count_d = out_count_q;
        out_sat_d   = out_sat_q;
        out_valid_d = out_valid_q;
        case (state_q)
            S_ACC: begin
                if (accept) begin
                    acc_d = sum_clamped;
                    cnt_d = cnt_inc;
                    sat_d = sat_q | sum_ovf;
                    if (window_end) begin
                        out_sum_d   = sum_clamped;
                        out_count_d = cnt_inc;
                        out_sat_d   = sat_q | sum_ovf;
                        out_valid_d = 1'b1;
                        state_d     = S_OUT;
                    end
                end
            end
            S_OUT: begin
                // Result registers are untouched here so they stay stable until taken
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    acc_d       = '0;
                    cnt_d       = '0;
                    sat_d       = 1'b0;
                    state_d     = S_ACC;
                end
            end
            default: begin
                state_d = S_ACC;
            end
        endcase
    end

    // State and result registers; reset drops any partial window or pending result
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q     <= S_ACC;
            acc_q       <= '0;
            cnt_q       <= '0;
            sat_q       <= 1'b0;
            out_sum_q   <= '0;
            out_count_q <= '0;
            out_sat_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            sat_q       <= sat_d;
            out_sum_q   <= out_sum_d;
            out_count_q <= out_count_d;
            out_sat_q   <= out_sat_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_mean_shift_window_accum.sv
// tb/tb_mean_shift_window_accum.sv - self-checking bench for mean_shift_window_accum
module tb_mean_shift_window_accum;

    localparam longint ACC_MAX = 64'sd8388607;
    localparam longint ACC_MIN = -64'sd8388608;

    logic               ap_clk = 1'b0;
    logic               ap_rst = 1'b1;
    logic               sel = 1'b0;
    logic signed [15:0] in_data = '0;
    logic               in_last = 1'b0;
    logic               in_valid = 1'b0;
    logic               out_ready = 1'b0;

    always #5 ap_clk = ~ap_clk;

    mean_shift_window_accum_if #(.DIN_WIDTH(16), .ACC_WIDTH(24), .CNT_WIDTH(7))  bus_a ();
    mean_shift_window_accum_if #(.DIN_WIDTH(16), .ACC_WIDTH(24), .CNT_WIDTH(10)) bus_b ();

    assign bus_a.in_data   = in_data;
    assign bus_a.in_last   = in_last;
    assign bus_a.in_valid  = in_valid && !sel;
    assign bus_a.out_ready = out_ready && !sel;
    assign bus_b.in_data   = in_data;
    assign bus_b.in_last   = in_last;
    assign bus_b.in_valid  = in_valid && sel;
    assign bus_b.out_ready = out_ready && sel;

    mean_shift_window_accum #(.DIN_WIDTH(16), .ACC_WIDTH(24), .CNT_WIDTH(7), .MAX_LEN(64)) dut_a (
        .ap_clk (ap_clk),
        .ap_rst (ap_rst),
        .bus    (bus_a)
    );

    mean_shift_window_accum #(.DIN_WIDTH(16), .ACC_WIDTH(24), .CNT_WIDTH(10), .MAX_LEN(512)) dut_b (
        .ap_clk (ap_clk),
        .ap_rst (ap_rst),
        .bus    (bus_b)
    );

    logic   cur_in_ready, cur_out_valid, cur_out_sat;
    longint cur_out_sum, cur_out_count;

    always_comb begin
        cur_in_ready  = sel ? bus_b.in_ready  : bus_a.in_ready;
        cur_out_valid = sel ? bus_b.out_valid : bus_a.out_valid;
        cur_out_sat   = sel ? bus_b.out_sat   : bus_a.out_sat;
        cur_out_sum   = sel ? longint'(bus_b.out_sum)   : longint'(bus_a.out_sum);
        cur_out_count = sel ? longint'(bus_b.out_count) : longint'(bus_a.out_count);
    end

    int     n_tests = 0;
    int     n_fail  = 0;

    // Reference model: running window sum clamped to the 24-bit range, sticky flag, sample count
    longint m_acc = 0;
    int     m_cnt = 0;
    bit     m_sat = 1'b0;
    int     m_max = 64;
    longint e_sum = 0;
    longint e_cnt = 0;
    bit     e_sat = 1'b0;
    int     stim[$];

    task automatic check(input string tag, input longint obs, input longint exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic bit model_accept(input longint d, input bit last);
        m_acc = m_acc + d;
        if (m_acc > ACC_MAX) begin
            m_acc = ACC_MAX;
            m_sat = 1'b1;
        end else if (m_acc < ACC_MIN) begin
            m_acc = ACC_MIN;
            m_sat = 1'b1;
        end
        m_cnt++;
        if (last || m_cnt == m_max) begin
            e_sum = m_acc;
            e_cnt = m_cnt;
            e_sat = m_sat;
            m_acc = 0;
            m_cnt = 0;
            m_sat = 1'b0;
            return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic check_result(input string tag);
        check({tag, "_sum"},   cur_out_sum,   e_sum);
        check({tag, "_count"}, cur_out_count, e_cnt);
        check({tag, "_sat"},   cur_out_sat,   e_sat);
    endtask

    // Feed stim[] until the model says the window closed; checks 1-cycle result latency
    task automatic send_stream(input string tag, input bit last_at_end, output bit terminated);
        int w;
        terminated = 1'b0;
        for (int i = 0; i < stim.size() && !terminated; i++) begin
            @(negedge ap_clk);
            in_valid = 1'b1;
            in_data  = 16'(stim[i]);
            in_last  = last_at_end && (i == stim.size() - 1);
            w = 0;
            while (!cur_in_ready && w < 20) begin
                @(negedge ap_clk);
                w++;
            end
            if (!cur_in_ready) begin
                check({tag, "_accept_timeout"}, 0, 1);
                break;
            end
            @(posedge ap_clk);
            terminated = model_accept(longint'(stim[i]), in_last);
        end
        @(negedge ap_clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (terminated) begin
            check({tag, "_latency_valid"}, cur_out_valid, 1);
            check_result(tag);
        end
    endtask

    // Hold the result for 'delay' cycles, then take it and confirm the block reopens next cycle
    task automatic handoff(input string tag, input int delay);
        for (int k = 0; k < delay; k++) begin
            @(negedge ap_clk);
            check({tag, "_hold_valid"}, cur_out_valid, 1);
            check({tag, "_hold_ready"}, cur_in_ready, 0);
            check({tag, "_hold_sum"},   cur_out_sum, e_sum);
        end
        @(negedge ap_clk);
        out_ready = 1'b1;
        @(posedge ap_clk);
        @(negedge ap_clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check({tag, "_after_valid"}, cur_out_valid, 0);
        check({tag, "_after_ready"}, cur_in_ready, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bit term;
        int len;

        // Reset state
        @(negedge ap_clk);
        check("rst_in_ready_a", bus_a.in_ready, 0);
        check("rst_in_ready_b", bus_b.in_ready, 0);
        @(negedge ap_clk);
        check("rst_out_valid", bus_a.out_valid, 0);
        check("rst_out_sum",   longint'(bus_a.out_sum), 0);
        check("rst_out_count", longint'(bus_a.out_count), 0);
        check("rst_out_sat",   bus_a.out_sat, 0);
        ap_rst = 1'b0;
        #1;
        check("rst_release_ready_a", bus_a.in_ready, 1);
        check("rst_release_ready_b", bus_b.in_ready, 1);

        // Four-sample window closed by in_last
        stim = '{100, -50, 300, 7};
        send_stream("basic", 1'b1, term);
        check("basic_exp_sum", e_sum, 357);
        handoff("basic", 0);

        // Window closed by the length limit, then ready stays low until taken
        stim.delete();
        for (int i = 0; i < 70; i++) stim.push_back(1);
        send_stream("maxlen", 1'b0, term);
        check("maxlen_exp_count", e_cnt, 64);
        handoff("maxlen", 3);

        // in_last coinciding with the 64th sample closes the window once
        stim.delete();
        for (int i = 0; i < 64; i++) stim.push_back(2);
        send_stream("last_at_max", 1'b1, term);
        handoff("last_at_max", 0);
        @(negedge ap_clk);
        check("last_at_max_no_dup", cur_out_valid, 0);

        // Saturation on the long-window instance
        sel   = 1'b1;
        m_max = 512;
        #1;
        stim.delete();
        for (int i = 0; i < 300; i++) stim.push_back(32767);
        send_stream("sat_pos", 1'b1, term);
        check("sat_pos_exp", e_sum, 8388607);
        handoff("sat_pos", 1);

        stim = '{-1};
        send_stream("sat_clear", 1'b1, term);
        handoff("sat_clear", 0);

        stim.delete();
        for (int i = 0; i < 300; i++) stim.push_back(-32768);
        send_stream("sat_neg", 1'b1, term);
        handoff("sat_neg", 0);

        // Clamp then keep summing from the clamped value with the flag held
        stim.delete();
        for (int i = 0; i < 256; i++) stim.push_back(32767);
        stim.push_back(1000);
        stim.push_back(-1000);
        send_stream("sat_resume", 1'b1, term);
        check("sat_resume_exp", e_sum, 8387607);
        handoff("sat_resume", 0);

        sel   = 1'b0;
        m_max = 64;
        #1;

        // Back-pressure: new data offered while the result is held must not be consumed
        stim = '{10, 20};
        send_stream("bp", 1'b1, term);
        @(negedge ap_clk);
        in_valid = 1'b1;
        in_data  = 16'sd999;
        in_last  = 1'b1;
        handoff("bp", 10);
        in_last = 1'b0;
        stim = '{3, 4};
        send_stream("bp_next", 1'b1, term);
        check("bp_next_exp", e_sum, 7);
        handoff("bp_next", 0);

        // Single-sample windows with out_ready tied high: one accept every two cycles
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = -16'sd32768;
        in_last   = 1'b1;
        for (int k = 0; k < 6; k++) begin
            check("b2b_in_ready",  cur_in_ready,  (k % 2 == 0) ? 1 : 0);
            check("b2b_out_valid", cur_out_valid, (k % 2 == 1) ? 1 : 0);
            if (k % 2 == 1) begin
                check("b2b_sum",   cur_out_sum, -32768);
                check("b2b_count", cur_out_count, 1);
            end
            @(negedge ap_clk);
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;

        // Reset mid-window discards the partial sum
        stim = '{1, 2, 3};
        send_stream("midrst", 1'b0, term);
        ap_rst = 1'b1;
        #1;
        check("midrst_ready_low", cur_in_ready, 0);
        @(negedge ap_clk);
        ap_rst = 1'b0;
        m_acc  = 0;
        m_cnt  = 0;
        m_sat  = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge ap_clk);
            check("midrst_no_output", cur_out_valid, 0);
        end
        stim = '{5, 5};
        send_stream("midrst_next", 1'b1, term);
        check("midrst_next_exp", e_sum, 10);
        handoff("midrst_next", 0);

        // Randomized windows against the model
        for (int r = 0; r < 8; r++) begin
            len = int'($urandom_range(1, 80));
            stim.delete();
            for (int i = 0; i < len; i++) stim.push_back(int'($signed(16'($urandom))));
            send_stream("rand", len <= 64, term);
            check("rand_terminated", term, 1);
            handoff("rand", int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
